// File: rtl/prio_req_encoder_pkg.sv
// Shared constants and helpers for the priority request encoder.
// Holds the mode selectors, the index-width function and the one-hot helper.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2. The caller applies the minimum width of 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [63:0] onehot(input int idx, input int n);
    logic [63:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < 64) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_req_encoder_if.sv
// Request/grant bundle between the request sources, the encoder and the consumer.
// Handshake: a grant (oIdx) is offered while oValid=1 and is consumed on an edge where iAck=1.
interface prio_req_encoder_if #(
  parameter int N = 8
) ();
  import prio_enc_pkg::*;

  localparam int W = (clog2(N) < 1) ? 1 : clog2(N);

  logic [N-1:0] iData;
  logic         iEI;
  logic         iAck;
  logic         oValid;
  logic [W-1:0] oIdx;
  logic         oEO;

  modport master (
    output iData, iEI, iAck,
    input  oValid, oIdx, oEO
  );

  modport slave (
    input  iData, iEI, iAck,
    output oValid, oIdx, oEO
  );
endinterface

// File: rtl/prio_req_encoder_select.sv
// Combinational masked search: first set bit of cand scanning downward from start-1,
// wrapping from 0 to N-1. A start of 0 therefore means plain highest-index-wins.
module prio_select #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Position k of the scan is (start - 1 - k) mod N, kept non-negative by adding N.
    for (int k = 0; k < N; k++) begin
      if (!found && cand[(int'(start) + N - 1 - k) % N]) begin
        idx   = W'((int'(start) + N - 1 - k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Registered N-channel priority request encoder with sticky pending latches,
// optional round-robin selection and a hold-until-acknowledged grant output.
module prio_req_encoder
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED
) (
  input  logic               iClk,
  input  logic               iRst_n,
  prio_req_encoder_if.slave  bus
);

  localparam int W = (clog2(N) < 1) ? 1 : clog2(N);

  logic [N-1:0] pend_q, pend_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [N-1:0] ack_mask;
  logic [N-1:0] cand;
  logic         load;
  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic [W-1:0] sel_start;

  // A low request line sets its pending bit even on the edge that acks it.
  always_comb begin
    ack_mask = (valid_q && bus.iAck) ? N'(onehot(int'(idx_q), N)) : '0;
    cand     = (pend_q & ~ack_mask) | ~bus.iData;
    load     = !valid_q || bus.iAck;
  end

  assign sel_start = (MODE == MODE_RR) ? ptr_q : '0;

  prio_select #(
    .N (N),
    .W (W)
  ) u_select (
    .cand  (cand),
    .start (sel_start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // A live grant is never replaced until acked, whatever iEI or new requests do.
  always_comb begin
    pend_d  = cand;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (!bus.iEI && sel_found) begin
        valid_d = 1'b1;
        idx_d   = sel_idx;
        if (MODE == MODE_RR) ptr_d = sel_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.oValid = valid_q;
  assign bus.oIdx   = idx_q;
  assign bus.oEO    = ~(~bus.iEI & (pend_q == '0) & ~valid_q);

endmodule
